// File: rtl/se_pack.sv
// Two-stage narrowing pipeline: packs a signed 64-bit value into a WIDTH-bit signed field,
// either wrapping or saturating, and counts delivered overflows.
module se_pack #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic [15:0]      ovf_cnt,
  input  logic             cnt_clr
);

  localparam int unsigned HiW = 65 - WIDTH;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_low_q;
  logic             s1_sign_q;
  logic             s1_sat_q;
  logic             s1_fit_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_ovf_q;
  logic [15:0]      ovf_cnt_q;
  logic [15:0]      ovf_cnt_d;

  logic             advance;
  logic [HiW-1:0]   in_hi;
  logic             in_fit;
  logic [WIDTH-1:0] s2_data_d;
  logic             hs_ovf;

  // The value fits when every bit from the field's sign bit upward is a copy of the sign.
  assign in_hi  = in_data[63:WIDTH-1];
  assign in_fit = (&in_hi) | ~(|in_hi);

  assign advance  = ~out_valid_q | out_ready;
  // While reset is held the pipeline is being flushed, so upstream is never back-pressured.
  assign in_ready = advance | ~reset;

  always_comb begin
    s2_data_d = s1_low_q;
    if (!s1_fit_q && s1_sat_q) begin
      s2_data_d = s1_sign_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  assign hs_ovf = out_valid_q & out_ready & out_ovf_q;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (cnt_clr) begin
      ovf_cnt_d = {15'd0, hs_ovf};
    end else if (hs_ovf && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_low_q    <= '0;
      s1_sign_q   <= 1'b0;
      s1_sat_q    <= 1'b0;
      s1_fit_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      ovf_cnt_q   <= 16'd0;
    end else begin
      if (advance) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_low_q  <= in_data[WIDTH-1:0];
          s1_sign_q <= in_data[63];
          s1_sat_q  <= in_sat;
          s1_fit_q  <= in_fit;
        end
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_data_q <= s2_data_d;
          out_ovf_q  <= ~s1_fit_q;
        end
      end
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_se_pack.sv
// Self-checking bench for se_pack: directed corner cases plus randomized traffic scored
// against an arithmetic reference model.
module tb_se_pack;

  localparam int W = 9;

  typedef struct packed {
    logic [W-1:0] data;
    logic         ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_data;
  logic          in_sat;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_ovf;
  logic [15:0]   ovf_cnt;
  logic          cnt_clr;

  int            n_checks = 0;
  int            n_errors = 0;
  int            n_out = 0;
  exp_t          exp_q[$];
  logic [15:0]   model_cnt = 16'd0;
  logic [W-1:0]  last_data;
  logic          last_ovf;
  logic          stall_prev = 1'b0;
  logic [W-1:0]  prev_data;
  logic          prev_ovf;
  logic          done;

  se_pack #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sat    (in_sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .ovf_cnt   (ovf_cnt),
    .cnt_clr   (cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: range test on the signed value, then clamp or truncate.
  function automatic exp_t model(input logic [63:0] d, input logic sat);
    longint v;
    longint maxv;
    longint minv;
    exp_t   e;
    v     = longint'(d);
    maxv  = (longint'(1) <<< (W - 1)) - 1;
    minv  = -maxv - 1;
    e.ovf = (v > maxv) || (v < minv);
    if (e.ovf && sat) e.data = (v < 0) ? minv[W-1:0] : maxv[W-1:0];
    else              e.data = d[W-1:0];
    return e;
  endfunction

  function automatic logic [63:0] rand_data();
    logic [63:0] r;
    logic [9:0]  s10;
    logic [15:0] s16;
    case ($urandom_range(0, 3))
      0: r = {$urandom(), $urandom()};
      1: begin s10 = 10'($urandom()); r = {{54{s10[9]}}, s10}; end
      2: begin
        case ($urandom_range(0, 5))
          0:       r = 64'h0000_0000_0000_00FF;
          1:       r = 64'h0000_0000_0000_0100;
          2:       r = 64'hFFFF_FFFF_FFFF_FF00;
          3:       r = 64'hFFFF_FFFF_FFFF_FEFF;
          4:       r = 64'h0;
          default: r = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
      end
      default: begin s16 = 16'($urandom()); r = {{48{s16[15]}}, s16}; end
    endcase
    return r;
  endfunction

  // Scoreboard: everything sampled at the falling edge, describing the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    logic hs_ovf;
    check("ovf_cnt", ovf_cnt, model_cnt);
    if (!reset) begin
      exp_q.delete();
      model_cnt  = 16'd0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_ovf", out_ovf, prev_ovf);
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_ovf   = out_ovf;
      check("in_ready", in_ready, !out_valid || out_ready);
      hs_ovf = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_ovf", out_ovf, e.ovf);
          hs_ovf = e.ovf;
        end
        n_out++;
        last_data = out_data;
        last_ovf  = out_ovf;
      end
      if (cnt_clr)                               model_cnt = {15'd0, hs_ovf};
      else if (hs_ovf && model_cnt != 16'hFFFF)  model_cnt = model_cnt + 16'd1;
      if (in_valid && in_ready) exp_q.push_back(model(in_data, in_sat));
    end
  end

  task automatic send(input logic [63:0] d, input logic s);
    bit acc = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    in_sat   = s;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin acc = 1'b1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int acc;
    int guard;
    reset = 1'b0; in_valid = 1'b1; in_data = 64'h1234; in_sat = 1'b0;
    out_ready = 1'b1; cnt_clr = 1'b0; done = 1'b0;

    // Reset state; the input offered during reset must never emerge.
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ovf", out_ovf, 0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    repeat (4) @(negedge clk);

    // Latency: presented before edge P1, visible after edge P2.
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 64'hFF; in_sat = 1'b0;
    @(negedge clk); check("lat_accept", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); check("lat_edge1_valid", out_valid, 0);
    @(negedge clk);
    check("lat_edge2_valid", out_valid, 1);
    check("lat_data", out_data, 9'h0FF);
    check("lat_ovf", out_ovf, 0);
    drain();

    // Positive overflow, saturate then wrap.
    send(64'h100, 1'b1); drain();
    check("pos_sat_data", last_data, 9'h0FF);
    check("pos_sat_ovf", last_ovf, 1);
    send(64'h100, 1'b0); drain();
    check("pos_wrap_data", last_data, 9'h100);
    check("pos_wrap_ovf", last_ovf, 1);
    check("ovf_cnt_two", ovf_cnt, 2);

    // Negative boundary and just below it.
    send(64'hFFFF_FFFF_FFFF_FF00, 1'b0); drain();
    check("neg_fit_data", last_data, 9'h100);
    check("neg_fit_ovf", last_ovf, 0);
    send(64'hFFFF_FFFF_FFFF_FEFF, 1'b1); drain();
    check("neg_sat_data", last_data, 9'h100);
    check("neg_sat_ovf", last_ovf, 1);

    // Back-pressure: fill both stages, hold, then release.
    base = n_out;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'd1; in_sat = 1'b0;
    @(posedge clk); #1 in_data = 64'd2;
    @(posedge clk); #1 in_data = 64'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_data", out_data, 9'd1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 20 && acc == 0; i++) begin
      @(negedge clk);
      if (in_ready) acc = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("stall_last_accept", acc, 1);
    drain();
    check("stall_delivered", n_out - base, 3);

    // Reset mid-stall with two items in flight.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h200; in_sat = 1'b0;
    @(posedge clk); #1 in_data = 64'h7;
    @(posedge clk); #1 in_data = 64'h55; reset = 1'b0;
    base = n_out;
    @(negedge clk); check("rst2_in_ready", in_ready, 1);
    @(negedge clk);
    check("rst2_out_valid", out_valid, 0);
    check("rst2_ovf_cnt", ovf_cnt, 0);
    @(posedge clk); #1 reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("rst2_no_stale", n_out - base, 0);

    // Counter saturation: 65535 overflows to reach the ceiling, then one more.
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 64'h100; in_sat = 1'b1;
    acc = 0; guard = 0;
    while (acc < 65536 && guard < 70000) begin
      @(negedge clk);
      if (in_ready) acc++;
      guard++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("sat_stream_accepted", acc, 65536);
    drain();
    check("ovf_cnt_saturated", ovf_cnt, 16'hFFFF);

    // Clear coinciding with an overflowed handshake.
    @(posedge clk); #1 out_ready = 1'b0;
    send(64'h100, 1'b0);
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin acc = 1; break; end
    end
    check("clr_item_ready", acc, 1);
    @(posedge clk); #1 out_ready = 1'b1; cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    @(negedge clk); check("clr_with_ovf", ovf_cnt, 1);

    // Randomized traffic with random back-pressure and occasional clears.
    fork
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
          cnt_clr   = ($urandom_range(0, 99) == 0);
        end
      end
      begin
        for (int i = 0; i < 1500; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send(rand_data(), 1'($urandom_range(0, 1)));
        end
        done = 1'b1;
      end
    join
    out_ready = 1'b1; cnt_clr = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
